clk_bringup_seq: RTL and testbench
==================================

// Module: clk_bringup_seq
// PURPOSE
//  Hardware power-up/reclock sequencer for the PL clock tree, in the pl_clk0 domain. Replaces
//  software poking of the GPIO control bits. Sequence: reset TCXO 96M PLL, wait for lock; reset
//  ClkWiz, set its source, wait for lock; optionally check frequency; release sys_reset.
//  Monitors lock in RUN and reports faults.
// PARAMETERS
//  RST_CYCLES    16       pl_clk0 cycles each PLL/ClkWiz reset is held asserted
//  LOCK_TIMEOUT  2**20    pl_clk0 cycles allowed for a lock to assert
//  GATE_CYCLES   1000     fmeas_en high time (pl_clk0 cycles) when FMEAS check compiled in
//  SETTLE_CYCLES 8        wait after fmeas_en falls before sampling count (CDC settle)
//  FMEAS_MIN     24'd950  lowest acceptable clk_fmeas_count
//  FMEAS_MAX     24'd1050 highest acceptable clk_fmeas_count
// PORTS
//  pl_clk0          in   1   sequencer clock
//  pl_reset_n       in   1   asynchronous, active-low reset
//  start            in   1   pulse: begin/restart full sequence (ignored in TCXO_*/CLK_* states)
//  src_sel_cfg      in   1   ClkWiz input select applied at CLK_RST (0 = pl_clk0, 1 = TCXO_96M)
//  tcxo_96m_reset   out  1   to TCXO PLL reset CDC
//  tcxo_96m_locked  in   1   TCXO PLL lock, already synchronised to pl_clk0
//  clk_reset        out  1   ClkWiz reset
//  clk_src_sel      out  1   registered ClkWiz source select
//  clk_locked       in   1   ClkWiz lock, already synchronised to pl_clk0
//  clk_fmeas_en     out  1   frequency-meter gate
//  clk_fmeas_count  in   24  frequency-meter result, pl_clk0 domain
//  sys_reset        out  1   clk-domain logic reset request
//  busy             out  1   high in any state other than IDLE/RUN/FAULT
//  ready            out  1   high only in RUN
//  fault            out  1   high only in FAULT
//  fault_code       out  3   0 none, 1 TCXO timeout, 2 ClkWiz timeout, 3 freq range, 4 lock lost
// BEHAVIOUR
//  Reset values: tcxo_96m_reset=1, clk_reset=1, sys_reset=1, clk_src_sel=0, clk_fmeas_en=0,
//   busy=0, ready=0, fault=0, fault_code=0. State=IDLE.
//  One down-counter (>=24 bit) is shared; it is reloaded on every state entry.
//  IDLE: all resets asserted; start -> TCXO_RST.
//  TCXO_RST: tcxo_96m_reset=1 for RST_CYCLES, then -> TCXO_WAIT (deassert).
//  TCXO_WAIT: tcxo_96m_locked -> CLK_RST; LOCK_TIMEOUT expiry -> FAULT code 1.
//   Skipped (TCXO_RST -> CLK_RST directly) only when src_sel_cfg=0 was latched at start.
//  CLK_RST: clk_src_sel<=latched src_sel_cfg on entry; clk_reset=1 for RST_CYCLES -> CLK_WAIT.
//  CLK_WAIT: clk_locked -> FMEAS_RUN (macro) or RELEASE; timeout -> FAULT code 2.
//  RELEASE: sys_reset held 1 for one further cycle, then 0 on the cycle RUN is entered.
//  RUN: ready=1. Either lock (tcxo only if TCXO selected) low for 1 cycle -> sys_reset=1 on the
//   next edge, then FAULT code 4. start in RUN -> TCXO_RST (reclock; sys_reset reasserted first).
//  FAULT: sys_reset=1, resets asserted; fault_code holds until start, which clears it and enters
//   TCXO_RST.
//  Simultaneous lock-loss and start in RUN: lock-loss wins (FAULT code 4).
//  src_sel_cfg is sampled only on the start cycle; later changes take effect on the next start.
//  Asynchronous reset mid-sequence returns to IDLE with reset values immediately.
//  Lock inputs must be seen high 2 consecutive cycles to count as locked (glitch filter).
// CONFIGURATION
//  CLK_SEQ_FMEAS_CHECK_EN defined: after CLK_WAIT: FMEAS_RUN (clk_fmeas_en=1 for GATE_CYCLES),
//   FMEAS_SETTLE (en=0, SETTLE_CYCLES), FMEAS_CHECK (1 cycle: FMEAS_MIN<=count<=FMEAS_MAX,
//   inclusive -> RELEASE, else FAULT code 3).
//  Undefined: FMEAS states removed, clk_fmeas_en tied 0, code 3 never produced.
// TESTING
//  Reset, start, src_sel_cfg=1, both locks rise 50 cycles after deassert -> ready=1, sys_reset=0,
//   tcxo_96m_reset/clk_reset each high exactly 16 cycles.
//  src_sel_cfg=1, tcxo_96m_locked never rises, LOCK_TIMEOUT=100 -> fault=1, fault_code=1 at
//   cycle 100 of TCXO_WAIT.
//  In RUN drop clk_locked 1 cycle -> sys_reset=1 next cycle, fault_code=4; start -> resequence.
//  Macro on, count=1050 -> RUN; count=1051 -> FAULT code 3; count=949 -> FAULT code 3.
//  1-cycle lock glitch in CLK_WAIT -> no transition; start during CLK_WAIT -> ignored.
//  pl_reset_n low mid CLK_WAIT -> all outputs at reset values same cycle, state IDLE.

Source files
------------

// File: rtl/clk_bringup_seq.sv
// PL clock-tree power-up / reclock sequencer (pl_clk0 domain).
// Optional post-lock frequency check compiled in with `define CLK_SEQ_FMEAS_CHECK_EN.
module clk_bringup_seq #(
  parameter int          RST_CYCLES    = 16,
  parameter int          LOCK_TIMEOUT  = 2**20,
  parameter int          GATE_CYCLES   = 1000,
  parameter int          SETTLE_CYCLES = 8,
  parameter logic [23:0] FMEAS_MIN     = 24'd950,
  parameter logic [23:0] FMEAS_MAX     = 24'd1050
) (
  input  logic        pl_clk0,
  input  logic        pl_reset_n,
  input  logic        start,
  input  logic        src_sel_cfg,
  output logic        tcxo_96m_reset,
  input  logic        tcxo_96m_locked,
  output logic        clk_reset,
  output logic        clk_src_sel,
  input  logic        clk_locked,
  output logic        clk_fmeas_en,
  input  logic [23:0] clk_fmeas_count,
  output logic        sys_reset,
  output logic        busy,
  output logic        ready,
  output logic        fault,
  output logic [2:0]  fault_code
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TCXO_RST,
    S_TCXO_WAIT,
    S_CLK_RST,
    S_CLK_WAIT,
`ifdef CLK_SEQ_FMEAS_CHECK_EN
    S_FMEAS_RUN,
    S_FMEAS_SETTLE,
    S_FMEAS_CHECK,
`endif
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [23:0] r_cnt;
  logic [2:0]  r_code;
  logic [2:0]  w_code_nxt;
  logic        r_tcxo_lk_d;
  logic        r_clk_lk_d;
  logic        r_src_latch;
  logic        r_tcxo_rst;
  logic        r_clk_rst;
  logic        r_src_sel;
  logic        r_sys_rst;
  logic        r_busy;
  logic        r_ready;
  logic        r_fault;
  logic        w_tcxo_ok;
  logic        w_clk_ok;
  logic        w_cnt_done;
  logic        w_lock_lost;

  // Shared down-counter reload value for the state being entered.
  function automatic logic [23:0] load_val(input state_t s);
    case (s)
      S_TCXO_RST, S_CLK_RST:   load_val = 24'(RST_CYCLES - 1);
      S_TCXO_WAIT, S_CLK_WAIT: load_val = 24'(LOCK_TIMEOUT - 1);
`ifdef CLK_SEQ_FMEAS_CHECK_EN
      S_FMEAS_RUN:             load_val = 24'(GATE_CYCLES - 1);
      S_FMEAS_SETTLE:          load_val = 24'(SETTLE_CYCLES - 1);
`endif
      default:                 load_val = 24'd0;
    endcase
  endfunction

  // Two consecutive high samples are needed before a lock counts.
  assign w_tcxo_ok   = tcxo_96m_locked & r_tcxo_lk_d;
  assign w_clk_ok    = clk_locked & r_clk_lk_d;
  assign w_cnt_done  = (r_cnt == 24'd0);
  assign w_lock_lost = !clk_locked || (r_src_sel && !tcxo_96m_locked);

  always_comb begin
    w_nxt      = r_state;
    w_code_nxt = r_code;
    case (r_state)
      S_IDLE: if (start) w_nxt = S_TCXO_RST;
      S_TCXO_RST: if (w_cnt_done) w_nxt = r_src_latch ? S_TCXO_WAIT : S_CLK_RST;
      S_TCXO_WAIT: begin
        if (w_tcxo_ok) w_nxt = S_CLK_RST;
        else if (w_cnt_done) begin
          w_nxt      = S_FAULT;
          w_code_nxt = 3'd1;
        end
      end
      S_CLK_RST: if (w_cnt_done) w_nxt = S_CLK_WAIT;
      S_CLK_WAIT: begin
        if (w_clk_ok) begin
`ifdef CLK_SEQ_FMEAS_CHECK_EN
          w_nxt = S_FMEAS_RUN;
`else
          w_nxt = S_RELEASE;
`endif
        end else if (w_cnt_done) begin
          w_nxt      = S_FAULT;
          w_code_nxt = 3'd2;
        end
      end
`ifdef CLK_SEQ_FMEAS_CHECK_EN
      S_FMEAS_RUN:    if (w_cnt_done) w_nxt = S_FMEAS_SETTLE;
      S_FMEAS_SETTLE: if (w_cnt_done) w_nxt = S_FMEAS_CHECK;
      S_FMEAS_CHECK: begin
        if (clk_fmeas_count >= FMEAS_MIN && clk_fmeas_count <= FMEAS_MAX) w_nxt = S_RELEASE;
        else begin
          w_nxt      = S_FAULT;
          w_code_nxt = 3'd3;
        end
      end
`endif
      S_RELEASE: w_nxt = S_RUN;
      // Lock loss outranks a reclock request.
      S_RUN: begin
        if (w_lock_lost) begin
          w_nxt      = S_FAULT;
          w_code_nxt = 3'd4;
        end else if (start) w_nxt = S_TCXO_RST;
      end
      S_FAULT: begin
        if (start) begin
          w_nxt      = S_TCXO_RST;
          w_code_nxt = 3'd0;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
    if (!pl_reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 24'd0;
      r_code      <= 3'd0;
      r_tcxo_lk_d <= 1'b0;
      r_clk_lk_d  <= 1'b0;
      r_src_latch <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_code      <= w_code_nxt;
      r_tcxo_lk_d <= tcxo_96m_locked;
      r_clk_lk_d  <= clk_locked;
      if (w_nxt != r_state) r_cnt <= load_val(w_nxt);
      else if (!w_cnt_done) r_cnt <= r_cnt - 24'd1;
      if (w_nxt == S_TCXO_RST && r_state != S_TCXO_RST) r_src_latch <= src_sel_cfg;
    end
  end

  // Outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
    if (!pl_reset_n) begin
      r_tcxo_rst <= 1'b1;
      r_clk_rst  <= 1'b1;
      r_sys_rst  <= 1'b1;
      r_src_sel  <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_tcxo_rst <= (w_nxt inside {S_IDLE, S_TCXO_RST, S_FAULT});
      r_clk_rst  <= (w_nxt inside {S_IDLE, S_CLK_RST, S_FAULT});
      r_sys_rst  <= (w_nxt != S_RUN);
      r_busy     <= !(w_nxt inside {S_IDLE, S_RUN, S_FAULT});
      r_ready    <= (w_nxt == S_RUN);
      r_fault    <= (w_nxt == S_FAULT);
      if (w_nxt == S_CLK_RST && r_state != S_CLK_RST) r_src_sel <= r_src_latch;
    end
  end

`ifdef CLK_SEQ_FMEAS_CHECK_EN
  logic r_fmeas_en;
  always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
    if (!pl_reset_n) r_fmeas_en <= 1'b0;
    else             r_fmeas_en <= (w_nxt == S_FMEAS_RUN);
  end
  assign clk_fmeas_en = r_fmeas_en;
`else
  logic w_unused_fmeas;
  assign w_unused_fmeas = ^{clk_fmeas_count, 24'(GATE_CYCLES), 24'(SETTLE_CYCLES),
                            FMEAS_MIN, FMEAS_MAX};
  assign clk_fmeas_en   = 1'b0;
`endif

  assign tcxo_96m_reset = r_tcxo_rst;
  assign clk_reset      = r_clk_rst;
  assign clk_src_sel    = r_src_sel;
  assign sys_reset      = r_sys_rst;
  assign busy           = r_busy;
  assign ready          = r_ready;
  assign fault          = r_fault;
  assign fault_code     = r_code;

endmodule

// File: tb/tb_clk_bringup_seq.sv
// Directed bench for clk_bringup_seq; lock inputs come from a simple PLL model
// that locks 50 cycles after its reset is released.
module tb_clk_bringup_seq;
  logic        pl_clk0 = 1'b0;
  logic        pl_reset_n = 1'b0;
  logic        start = 1'b0;
  logic        src_sel_cfg = 1'b0;
  logic        tcxo_96m_locked = 1'b0;
  logic        clk_locked = 1'b0;
  logic [23:0] clk_fmeas_count = 24'd0;
  logic        tcxo_96m_reset, clk_reset, clk_src_sel, clk_fmeas_en;
  logic        sys_reset, busy, ready, fault;
  logic [2:0]  fault_code;

  int n_checks = 0;
  int n_fail   = 0;
  int t_cnt    = 0;
  int c_cnt    = 0;
  bit t_auto   = 1'b0;
  bit c_auto   = 1'b0;
  bit fmeas_seen = 1'b0;

  always #5 pl_clk0 = ~pl_clk0;

  clk_bringup_seq #(.LOCK_TIMEOUT(100)) u_dut (
    .pl_clk0         (pl_clk0),
    .pl_reset_n      (pl_reset_n),
    .start           (start),
    .src_sel_cfg     (src_sel_cfg),
    .tcxo_96m_reset  (tcxo_96m_reset),
    .tcxo_96m_locked (tcxo_96m_locked),
    .clk_reset       (clk_reset),
    .clk_src_sel     (clk_src_sel),
    .clk_locked      (clk_locked),
    .clk_fmeas_en    (clk_fmeas_en),
    .clk_fmeas_count (clk_fmeas_count),
    .sys_reset       (sys_reset),
    .busy            (busy),
    .ready           (ready),
    .fault           (fault),
    .fault_code      (fault_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: land on the falling edge, then update the PLL models.
  task automatic step();
    @(negedge pl_clk0);
    t_cnt = tcxo_96m_reset ? 0 : t_cnt + 1;
    c_cnt = clk_reset ? 0 : c_cnt + 1;
    if (t_auto) tcxo_96m_locked = (t_cnt >= 50);
    if (c_auto) clk_locked = (c_cnt >= 50);
    if (clk_fmeas_en) fmeas_seen = 1'b1;
  endtask

  task automatic pulse_start(input bit sel);
    src_sel_cfg = sel;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_ready(input int lim);
    for (int i = 0; i < lim && !ready; i++) step();
  endtask

  task automatic wait_fault(input int lim);
    for (int i = 0; i < lim && !fault; i++) step();
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_tcxo_rst"}, tcxo_96m_reset, 1);
    chk({pfx, "_clk_rst"},  clk_reset, 1);
    chk({pfx, "_sys_rst"},  sys_reset, 1);
    chk({pfx, "_src_sel"},  clk_src_sel, 0);
    chk({pfx, "_fmeas_en"}, clk_fmeas_en, 0);
    chk({pfx, "_busy"},     busy, 0);
    chk({pfx, "_ready"},    ready, 0);
    chk({pfx, "_fault"},    fault, 0);
    chk({pfx, "_code"},     fault_code, 0);
  endtask

  initial begin
    int n;
    repeat (3) step();
    check_reset("rst");
    pl_reset_n = 1'b1;
    repeat (2) step();

    // Full bring-up via TCXO.
    t_auto = 1'b1;
    c_auto = 1'b1;
    pulse_start(1'b1);
    n = 0;
    while (tcxo_96m_reset && n < 100) begin n++; step(); end
    chk("tcxo_rst_len", n, 16);
    n = 0;
    while (!clk_reset && n < 300) begin n++; step(); end
    n = 0;
    while (clk_reset && n < 100) begin n++; step(); end
    chk("clk_rst_len", n, 16);
    chk("src_sel_tcxo", clk_src_sel, 1);
    wait_ready(300);
    chk("run_ready", ready, 1);
    chk("run_sys_rst", sys_reset, 0);
    chk("run_busy", busy, 0);

    // Single-cycle ClkWiz lock drop in RUN, then restart.
    c_auto = 1'b0;
    clk_locked = 1'b0;
    step();
    c_auto = 1'b1;
    chk("lost_sys_rst", sys_reset, 1);
    chk("lost_fault", fault, 1);
    chk("lost_code", fault_code, 4);
    repeat (5) step();
    chk("lost_code_hold", fault_code, 4);
    pulse_start(1'b1);
    chk("restart_code_clr", fault_code, 0);
    chk("restart_busy", busy, 1);
    wait_ready(400);
    chk("restart_ready", ready, 1);

    // Lock loss and start in the same cycle.
    c_auto = 1'b0;
    clk_locked = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    c_auto = 1'b1;
    chk("simul_fault", fault, 1);
    chk("simul_code", fault_code, 4);

    // TCXO never locks.
    t_auto = 1'b0;
    tcxo_96m_locked = 1'b0;
    pulse_start(1'b1);
    n = 0;
    while (!fault && n < 500) begin
      if (!tcxo_96m_reset) n++;
      step();
    end
    chk("tcxo_to_cycles", n, 100);
    chk("tcxo_to_code", fault_code, 1);
    chk("tcxo_to_sys_rst", sys_reset, 1);

    // pl_clk0 source skips TCXO_WAIT; glitch and start ignored in CLK_WAIT; ClkWiz timeout.
    c_auto = 1'b0;
    clk_locked = 1'b0;
    pulse_start(1'b0);
    n = 0;
    while (tcxo_96m_reset && n < 100) begin n++; step(); end
    chk("skip_clk_rst", clk_reset, 1);
    chk("skip_src_sel", clk_src_sel, 0);
    n = 0;
    while (clk_reset && n < 100) begin n++; step(); end
    clk_locked = 1'b1;
    start = 1'b1;
    step();
    clk_locked = 1'b0;
    start = 1'b0;
    repeat (3) step();
    chk("glitch_busy", busy, 1);
    chk("glitch_tcxo_rst", tcxo_96m_reset, 0);
    chk("glitch_clk_rst", clk_reset, 0);
    chk("glitch_ready", ready, 0);
    wait_fault(200);
    chk("clk_to_code", fault_code, 2);

    // pl_clk0 source: TCXO lock is not monitored in RUN.
    c_auto = 1'b1;
    pulse_start(1'b0);
    wait_ready(400);
    chk("src0_ready", ready, 1);
    repeat (5) step();
    chk("src0_tcxo_ignored", ready, 1);

    // Asynchronous reset in CLK_WAIT.
    t_auto = 1'b1;
    pulse_start(1'b1);
    c_auto = 1'b0;
    clk_locked = 1'b0;
    n = 0;
    while (!clk_reset && n < 300) begin n++; step(); end
    n = 0;
    while (clk_reset && n < 100) begin n++; step(); end
    chk("cw_src_sel", clk_src_sel, 1);
    chk("cw_busy", busy, 1);
    #2 pl_reset_n = 1'b0;
    #1 check_reset("async");
    step();
    pl_reset_n = 1'b1;
    repeat (3) step();
    chk("idle_busy", busy, 0);
    chk("idle_tcxo_rst", tcxo_96m_reset, 1);

`ifdef CLK_SEQ_FMEAS_CHECK_EN
    c_auto = 1'b1;
    clk_fmeas_count = 24'd1050;
    pulse_start(1'b1);
    wait_ready(3000);
    chk("fm_1050_ready", ready, 1);
    clk_fmeas_count = 24'd1051;
    pulse_start(1'b1);
    wait_fault(3000);
    chk("fm_1051_code", fault_code, 3);
    clk_fmeas_count = 24'd949;
    pulse_start(1'b1);
    chk("fm_949_cleared", fault_code, 0);
    wait_fault(3000);
    chk("fm_949_code", fault_code, 3);
`else
    chk("fmeas_en_tied", fmeas_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
